mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- HI/LO multiply/divide unit for the pipelined MIPS CPU.
- Sits beside the EX stage. It consumes operands and the mult/div opcode from the ID/EX register and produces HI/LO for MFHI/MFLO.
- While an operation is in flight it raises busy. The hazard logic uses busy to stall any MFHI/MFLO/MTHI/MTLO/mult/div that reaches EX.

Parameters:
- MUL_CYCLES, 5, cycles from accepted start to HI/LO update for MULT/MULTU (1..15).
- DIV_CYCLES, 10, cycles from accepted start to HI/LO update for DIV/DIVU (1..15).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  EX-stage instruction is a mult/div/mthi/mtlo; sampled at clock edge
- op  input  3  md_op_t: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5 (6,7 reserved)
- a  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
- b  input  32  rt operand (divisor / multiplier)
- busy  output  1  operation in flight
- hi  output  32  architectural HI register
- lo  output  32  architectural LO register

Behaviour:
- Reset (asynchronous): busy=0, hi=0, lo=0, state=IDLE, counter=0, pending results=0.
- Reset mid-operation aborts the operation. HI/LO read 0, never the pending result.
- The state machine has three states: IDLE, MUL_RUN, DIV_RUN.
- Start is accepted only in IDLE. Start while busy=1 is ignored with no side effects; the CPU guarantees a stall, and the bench checks the ignore.
- MTHI/MTLO accepted at edge N: hi (or lo) = a after edge N. State stays IDLE and busy stays 0. The result is visible to an MFHI in EX at cycle N+1.
- MULT/MULTU accepted at edge N:
  - The 64-bit product is computed and latched into the pending regs at edge N, and the counter is loaded with MUL_CYCLES-1.
  - The state goes to MUL_RUN and busy=1 from edge N.
  - The counter decrements each edge. At the edge where counter==0, {hi,lo}=pending, the state returns to IDLE and busy drops.
  - HI/LO change at edge N+MUL_CYCLES. Busy is high for exactly MUL_CYCLES cycles.
- DIV/DIVU follow the same sequence using DIV_CYCLES and DIV_RUN: lo=quotient, hi=remainder.
- Arithmetic:
  - MULT: signed 32x32 -> 64.
  - MULTU: unsigned 32x32 -> 64.
  - DIV: signed. The quotient truncates toward zero and the remainder takes the sign of the dividend.
  - DIVU: unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
- Divide by zero: the unit still goes busy for DIV_CYCLES, and HI/LO are left unchanged at completion.
- Reserved op values: the start is ignored and the state stays IDLE.
- HI/LO are only ever written by this block. There is no flush input; the mult/div result commits even if a later instruction traps.
- Hi/lo outputs are direct register outputs with no combinational path from inputs.

Decomposition:
- The shared package holds:
  - md_op_t enum (3-bit) with the values above
  - state enum md_state_t {IDLE, MUL_RUN, DIV_RUN}
  - the localparam counter width of 4
- Optional sub-module md_signed_div: combinational 32-bit signed/unsigned quotient/remainder. It handles the divide-by-zero flag and the INT_MIN/-1 case, and keeps the sign rules out of the FSM.
- Multiply is inline.

Test Plan:
- Reset then MTHI a=0x12345678 -> next cycle hi=0x12345678, busy=0. MTLO a=0xDEADBEEF -> lo=0xDEADBEEF.
- MULT a=0xFFFFFFFE(-2), b=3 at edge N:
  - busy=1 for 5 cycles
  - at N+5: hi=0xFFFFFFFF, lo=0xFFFFFFFA
  - MULTU with the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU b=0 with hi=0xAAAA0000, lo=0x5555 preloaded -> busy for 10 cycles, HI/LO unchanged.
- Second MULT asserted during a DIV -> ignored: DIV result lands at N+10 and busy drops.
- Assert reset at cycle 3 of a MULT -> busy=0 and hi=lo=0 immediately; after reset releases, neither updates.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared types for the HI/LO multiply/divide unit.
//   md_op_t    : opcode presented with start (6 and 7 are reserved)
//   md_state_t : control FSM states
//   CNT_W      : width of the latency down-counter (latencies 1..15)
package mult_div_unit_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_signed_div.sv
// Combinational 32-bit divider producing quotient and remainder.
//   i_signed      : 1 = DIV (signed), 0 = DIVU
//   i_a, i_b      : dividend, divisor
//   o_quot        : quotient, truncated toward zero
//   o_rem         : remainder, sign follows the dividend
//   o_div_by_zero : divisor is zero; quotient/remainder are then meaningless
module md_signed_div (
    input  logic        i_signed,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem,
    output logic        o_div_by_zero
);

    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_divisor;
    logic [31:0] w_mag_q;
    logic [31:0] w_mag_r;

    // Divide magnitudes, then restore signs. INT_MIN has magnitude
    // 0x80000000 as an unsigned value, so INT_MIN / -1 yields 0x80000000
    // remainder 0 without any special case.
    assign w_neg_a = i_signed & i_a[31];
    assign w_neg_b = i_signed & i_b[31];
    assign w_mag_a = w_neg_a ? (~i_a + 32'd1) : i_a;
    assign w_mag_b = w_neg_b ? (~i_b + 32'd1) : i_b;

    assign o_div_by_zero = (i_b == 32'd0);

    // Keep the divider away from a zero divisor; the result is discarded.
    assign w_divisor = o_div_by_zero ? 32'd1 : w_mag_b;
    assign w_mag_q   = w_mag_a / w_divisor;
    assign w_mag_r   = w_mag_a % w_divisor;

    assign o_quot = (w_neg_a ^ w_neg_b) ? (~w_mag_q + 32'd1) : w_mag_q;
    assign o_rem  = w_neg_a ? (~w_mag_r + 32'd1) : w_mag_r;

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit beside the EX stage of the pipelined CPU.
// The result is computed at the accepting edge and held in pending
// registers; HI/LO are updated after the configured latency so that
// busy models the real unit's occupancy for the hazard logic.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   start, op    : EX-stage mult/div/mthi/mtlo request (accepted in IDLE)
//   a, b         : rs / rt operands
//   busy         : operation in flight
//   hi, lo       : architectural HI/LO registers
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_t        r_state;
    md_state_t        w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next_count;

    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_dbz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_mul_start;
    logic        w_div_start;
    logic        w_wr_hi;
    logic        w_wr_lo;
    logic        w_commit;

    logic        w_mul_signed;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_dbz;

    // Sign-extending both operands to 64 bits makes one unsigned multiplier
    // serve MULT and MULTU: the low 64 bits are correct in both cases.
    assign w_mul_signed = (op == MD_MULT);
    assign w_prod = {{32{w_mul_signed & a[31]}}, a} * {{32{w_mul_signed & b[31]}}, b};

    md_signed_div u_div (
        .i_signed      (op == MD_DIV),
        .i_a           (a),
        .i_b           (b),
        .o_quot        (w_quot),
        .o_rem         (w_rem),
        .o_div_by_zero (w_dbz)
    );

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_mul_start  = 1'b0;
        w_div_start  = 1'b0;
        w_wr_hi      = 1'b0;
        w_wr_lo      = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            w_mul_start  = 1'b1;
                            w_next_state = MUL_RUN;
                            w_next_count = MUL_LOAD;
                        end
                        MD_DIV, MD_DIVU: begin
                            w_div_start  = 1'b1;
                            w_next_state = DIV_RUN;
                            w_next_count = DIV_LOAD;
                        end
                        MD_MTHI: w_wr_hi = 1'b1;
                        MD_MTLO: w_wr_lo = 1'b1;
                        default: ;  // reserved opcodes are ignored
                    endcase
                end
            end
            MUL_RUN, DIV_RUN: begin
                if (r_count == '0) begin
                    w_commit     = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_count = r_count - 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
        end
    end

    // Pending results are reset too: an aborted operation must never leak
    // its result into HI/LO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend_hi  <= '0;
            r_pend_lo  <= '0;
            r_pend_dbz <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            if (w_mul_start) begin
                {r_pend_hi, r_pend_lo} <= w_prod;
                r_pend_dbz             <= 1'b0;
            end
            if (w_div_start) begin
                r_pend_hi  <= w_rem;
                r_pend_lo  <= w_quot;
                r_pend_dbz <= w_dbz;
            end
            if (w_wr_hi) r_hi <= a;
            if (w_wr_lo) r_lo <= a;
            // Divide by zero completes normally but leaves HI/LO untouched.
            if (w_commit && !r_pend_dbz) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end
    end

    assign busy = (r_state != IDLE);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
